// File: rtl/rv32i_types.sv
// Shared rv32i pipeline types: register index, data word and hazard-controller state.
package rv32i_types;

  typedef logic [4:0]  rv32i_reg;
  typedef logic [31:0] rv32i_word;

  typedef enum logic [1:0] {
    RUN,
    FREEZE,
    FLUSH_PEND
  } hazard_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear that takes priority over increment.
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline advance controller: memory-wait freeze, load-use bubble and branch flush,
// with saturating event counters.
module hazard_stall_unit
  import rv32i_types::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             imem_read,
  input  logic             imem_resp,
  input  logic             dmem_read,
  input  logic             dmem_write,
  input  logic             dmem_resp,
  input  rv32i_reg         id_rs1,
  input  rv32i_reg         id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  rv32i_reg         ex_rd,
  input  logic             ex_mem_read,
  input  logic             br_taken,
  input  logic             perf_clr,
  output logic             load_pc,
  output logic             load_if_id,
  output logic             load_id_ex,
  output logic             load_ex_mem,
  output logic             load_mem_wb,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             pc_redirect,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] bubble_count,
  output logic [CNT_W-1:0] flush_count
);

  hazard_state_t state_q;
  hazard_state_t state_d;

  logic mem_busy;
  logic load_use;
  logic do_flush;
  logic stall_inc;
  logic bubble_inc;
  logic flush_inc;

  assign mem_busy = (imem_read & ~imem_resp) | ((dmem_read | dmem_write) & ~dmem_resp);
  assign load_use = ex_mem_read & (ex_rd != 5'd0) &
                    ((id_rs1_used & (id_rs1 == ex_rd)) | (id_rs2_used & (id_rs2 == ex_rd)));
  assign do_flush = br_taken | (state_q == FLUSH_PEND);

  always_comb begin
    state_d     = state_q;
    load_pc     = 1'b0;
    load_if_id  = 1'b0;
    load_id_ex  = 1'b0;
    load_ex_mem = 1'b0;
    load_mem_wb = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    pc_redirect = 1'b0;
    stall_inc   = 1'b0;
    bubble_inc  = 1'b0;
    flush_inc   = 1'b0;

    if (mem_busy) begin
      // A taken branch seen during the wait is latched so it survives br_taken dropping.
      state_d   = do_flush ? FLUSH_PEND : FREEZE;
      stall_inc = 1'b1;
    end else begin
      state_d     = RUN;
      load_ex_mem = 1'b1;
      load_mem_wb = 1'b1;
      load_id_ex  = 1'b1;
      if (do_flush) begin
        load_pc     = 1'b1;
        load_if_id  = 1'b1;
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
        pc_redirect = 1'b1;
        flush_inc   = 1'b1;
      end else if (load_use) begin
        flush_id_ex = 1'b1;
        bubble_inc  = 1'b1;
      end else begin
        load_pc    = 1'b1;
        load_if_id = 1'b1;
      end
    end

    // Controls are combinational, so hold them quiet for the whole reset interval.
    if (!rst_n) begin
      load_pc     = 1'b0;
      load_if_id  = 1'b0;
      load_id_ex  = 1'b0;
      load_ex_mem = 1'b0;
      load_mem_wb = 1'b0;
      flush_if_id = 1'b0;
      flush_id_ex = 1'b0;
      pc_redirect = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .clr   (perf_clr),
    .count (stall_cycles)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (bubble_inc),
    .clr   (perf_clr),
    .count (bubble_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_inc),
    .clr   (perf_clr),
    .count (flush_count)
  );

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed and random checks of hazard_stall_unit against a pending-flag/saturating-count model.
module tb_hazard_stall_unit;

  localparam int unsigned W   = 4;
  localparam int          SAT = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         imem_read, imem_resp, dmem_read, dmem_write, dmem_resp;
  logic [4:0]   id_rs1, id_rs2, ex_rd;
  logic         id_rs1_used, id_rs2_used, ex_mem_read, br_taken, perf_clr;
  logic         load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
  logic         flush_if_id, flush_id_ex, pc_redirect;
  logic [W-1:0] stall_cycles, bubble_count, flush_count;

  hazard_stall_unit #(.CNT_W(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_read    (imem_read),
    .imem_resp    (imem_resp),
    .dmem_read    (dmem_read),
    .dmem_write   (dmem_write),
    .dmem_resp    (dmem_resp),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rs1_used  (id_rs1_used),
    .id_rs2_used  (id_rs2_used),
    .ex_rd        (ex_rd),
    .ex_mem_read  (ex_mem_read),
    .br_taken     (br_taken),
    .perf_clr     (perf_clr),
    .load_pc      (load_pc),
    .load_if_id   (load_if_id),
    .load_id_ex   (load_id_ex),
    .load_ex_mem  (load_ex_mem),
    .load_mem_wb  (load_mem_wb),
    .flush_if_id  (flush_if_id),
    .flush_id_ex  (flush_id_ex),
    .pc_redirect  (pc_redirect),
    .stall_cycles (stall_cycles),
    .bubble_count (bubble_count),
    .flush_count  (flush_count)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a taken branch seen while memory is busy is "owed"
  bit pend;
  int stall_m, bubble_m, flush_m;

  function automatic int sat_inc(input int v);
    return (v >= SAT) ? SAT : v + 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    imem_read = 0; imem_resp = 0; dmem_read = 0; dmem_write = 0; dmem_resp = 0;
    id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
    ex_rd = 0; ex_mem_read = 0; br_taken = 0; perf_clr = 0;
  endtask

  // Called just after a falling edge with inputs already applied.
  task automatic step(input string tag);
    bit busy, lu, fl;
    logic [7:0] exp;
    #1;
    busy = (imem_read && !imem_resp) || ((dmem_read || dmem_write) && !dmem_resp);
    lu = ex_mem_read && (ex_rd != 0) &&
         ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
    fl = br_taken || pend;
    if (!rst_n) begin
      pend = 0; stall_m = 0; bubble_m = 0; flush_m = 0;
      exp = 8'h00;
    end else if (busy) exp = 8'h00;
    else if (fl)       exp = 8'hFF;
    else if (lu)       exp = 8'b0011_1010;
    else               exp = 8'b1111_1000;
    check({tag, ".ctrl"}, 32'({load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
                              flush_if_id, flush_id_ex, pc_redirect}), 32'(exp));
    check({tag, ".stall"},  32'(stall_cycles), 32'(stall_m));
    check({tag, ".bubble"}, 32'(bubble_count), 32'(bubble_m));
    check({tag, ".flush"},  32'(flush_count),  32'(flush_m));
    @(posedge clk);
    if (rst_n) begin
      if (perf_clr) begin
        stall_m = 0; bubble_m = 0; flush_m = 0;
      end else if (busy) stall_m = sat_inc(stall_m);
      else if (fl)       flush_m = sat_inc(flush_m);
      else if (lu)       bubble_m = sat_inc(bubble_m);
      pend = busy ? (pend || br_taken) : 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 0;
    idle();
    pend = 0; stall_m = 0; bubble_m = 0; flush_m = 0;
    @(negedge clk);
    step("reset0");
    step("reset1");
    rst_n = 1;
    step("idle");

    // lw x5 in EX, add x6,x5,x1 in ID
    ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_rs1_used = 1; id_rs2 = 1; id_rs2_used = 1;
    step("lu_bubble");
    ex_mem_read = 0; ex_rd = 0;
    step("lu_after");

    // load into x0 is never a hazard
    ex_mem_read = 1; ex_rd = 0; id_rs1 = 0;
    step("lu_x0");
    idle();

    // four-cycle D-cache wait
    dmem_read = 1;
    for (int i = 0; i < 4; i++) step("dwait");
    dmem_resp = 1;
    step("dresp");
    idle();
    step("post_dwait");

    // branch during I-cache miss, br_taken drops while waiting
    imem_read = 1; br_taken = 1;
    step("br_miss0");
    br_taken = 0;
    step("br_miss1");
    step("br_miss2");
    imem_resp = 1;
    step("br_resp");
    idle();
    step("post_br");

    // flush beats load-use in the same advancing cycle
    br_taken = 1; ex_mem_read = 1; ex_rd = 7; id_rs2 = 7; id_rs2_used = 1;
    step("br_vs_lu");
    idle();

    // stall counter saturation, then clear with a simultaneous increment
    dmem_write = 1;
    for (int i = 0; i < 18; i++) step("sat");
    perf_clr = 1;
    step("clr_inc");
    perf_clr = 0;
    step("after_clr");
    idle();

    // asynchronous reset while a flush is pending discards it
    imem_read = 1; br_taken = 1;
    step("pend0");
    br_taken = 0;
    step("pend1");
    rst_n = 0;
    step("rst_mid");
    rst_n = 1; imem_resp = 1;
    step("rst_resume");
    idle();

    for (int n = 0; n < 400; n++) begin
      imem_read   = ($urandom_range(0, 3) == 0);
      imem_resp   = ($urandom_range(0, 1) == 0);
      dmem_read   = ($urandom_range(0, 4) == 0);
      dmem_write  = ($urandom_range(0, 6) == 0);
      dmem_resp   = ($urandom_range(0, 1) == 0);
      id_rs1      = 5'($urandom_range(0, 3));
      id_rs2      = 5'($urandom_range(0, 3));
      id_rs1_used = 1'($urandom_range(0, 1));
      id_rs2_used = 1'($urandom_range(0, 1));
      ex_rd       = 5'($urandom_range(0, 3));
      ex_mem_read = 1'($urandom_range(0, 1));
      br_taken    = ($urandom_range(0, 5) == 0);
      perf_clr    = ($urandom_range(0, 40) == 0);
      rst_n       = ($urandom_range(0, 120) != 0);
      step("rand");
    end
    rst_n = 1;
    idle();
    step("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
